// File: rtl/range_selector_q.sv
// range_selector_q: debounced rotary-encoder range selector driving decimation n and sample rate fc
module range_selector_q #(
   parameter int NUM_RANGES = 7,
   parameter int INIT_IDX   = 0,
   parameter int WRAP       = 0,
   parameter int DEB_CYCLES = 50000,
   parameter int N_W        = 10,
   parameter int FC_W       = 26
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a,
   input  logic            b,
   input  logic            key_n,
   output logic [2:0]      idx,
   output logic [N_W-1:0]  n,
   output logic [FC_W-1:0] fc,
   output logic            changed,
   output logic            at_min,
   output logic            at_max
);
   localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
   localparam logic [2:0] MAX_IDX = 3'(NUM_RANGES - 1);
   localparam logic [2:0] HOME_IDX = 3'(INIT_IDX);
   localparam int N_TBL [8] = '{1, 2, 4, 10, 20, 100, 200, 500};
   localparam int FC_TBL [8] = '{2000000, 1000000, 500000, 200000, 100000, 20000, 10000, 4000};
   logic [2:0] s1_q, s2_q, deb_q, dprev_q;
   logic [CW-1:0] cnt_q [3];
   logic [2:0] idx_q, idx_d, prev_q;
   logic [N_W-1:0] n_q;
   logic [FC_W-1:0] fc_q;
   logic changed_q;
   logic a_rise, up, dn, home;
   // two-flop synchroniser for {key_n, b, a}, idle level high
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '1;
         s2_q <= '1;
      end else begin
         s1_q <= {key_n, b, a};
         s2_q <= s1_q;
      end
   end
   // independent debounce per input; dprev_q keeps last debounced level for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_q   <= '1;
         dprev_q <= '1;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         dprev_q <= deb_q;
         for (int i = 0; i < 3; i++) begin
            if (s2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               deb_q[i] <= s2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end
   assign a_rise = deb_q[0] & ~dprev_q[0];
   assign up     = a_rise & ~deb_q[1];
   assign dn     = a_rise & deb_q[1];
   assign home   = ~deb_q[2] & dprev_q[2];
   // next index: home wins, then up/down with saturate or wrap at the ends
   always_comb begin
      idx_d = home ? HOME_IDX
            : up   ? (idx_q == MAX_IDX ? ((WRAP != 0) ? 3'd0 : idx_q) : idx_q + 3'd1)
            : dn   ? (idx_q == 3'd0 ? ((WRAP != 0) ? MAX_IDX : idx_q) : idx_q - 3'd1)
            : idx_q;
   end
   // index register plus table outputs and change strobe one clock behind it
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= HOME_IDX;
         prev_q    <= HOME_IDX;
         n_q       <= N_W'(N_TBL[INIT_IDX]);
         fc_q      <= FC_W'(FC_TBL[INIT_IDX]);
         changed_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         prev_q    <= idx_q;
         n_q       <= N_W'(N_TBL[idx_q]);
         fc_q      <= FC_W'(FC_TBL[idx_q]);
         changed_q <= idx_q != prev_q;
      end
   end
   assign idx     = idx_q;
   assign n       = n_q;
   assign fc      = fc_q;
   assign changed = changed_q;
   assign at_min  = idx_q == 3'd0;
   assign at_max  = idx_q == MAX_IDX;
endmodule

// File: tb/tb_range_selector_q.sv
// tb_range_selector_q: directed and random encoder stimulus checked against an arithmetic range model
module tb_range_selector_q;
   localparam int NR = 7, INIT = 0, DEB = 4, N_W = 10, FC_W = 26;
   logic clk = 1'b0;
   logic rst, a, b, key_n;
   logic [2:0] idx0, idx1;
   logic [N_W-1:0] n0, n1;
   logic [FC_W-1:0] fc0, fc1;
   logic ch0, ch1, mn0, mn1, mx0, mx1;
   int n_cmp = 0, n_err = 0;
   int p0 = 0, p1 = 0, e0 = 0, e1 = 0, m0 = INIT, m1 = INIT, base0, base1;
   int n_tbl [8] = '{1, 2, 4, 10, 20, 100, 200, 500};
   int fc_tbl [8] = '{2000000, 1000000, 500000, 200000, 100000, 20000, 10000, 4000};
   always #5 clk = ~clk;
   range_selector_q #(.NUM_RANGES(NR), .INIT_IDX(INIT), .WRAP(0), .DEB_CYCLES(DEB), .N_W(N_W), .FC_W(FC_W)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .key_n(key_n),
      .idx(idx0), .n(n0), .fc(fc0), .changed(ch0), .at_min(mn0), .at_max(mx0));
   range_selector_q #(.NUM_RANGES(NR), .INIT_IDX(INIT), .WRAP(1), .DEB_CYCLES(DEB), .N_W(N_W), .FC_W(FC_W)) dut_w (
      .clk(clk), .rst(rst), .a(a), .b(b), .key_n(key_n),
      .idx(idx1), .n(n1), .fc(fc1), .changed(ch1), .at_min(mn1), .at_max(mx1));
   always @(negedge clk) begin
      if (ch0) p0++;
      if (ch1) p1++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask
   task automatic hold(input int k);
      repeat (k) @(negedge clk);
   endtask
   task automatic settle_check(input string tag);
      chk({tag, " idx"}, 32'(idx0), 32'(m0));
      chk({tag, " n"}, 32'(n0), 32'(n_tbl[m0]));
      chk({tag, " fc"}, 32'(fc0), 32'(fc_tbl[m0]));
      chk({tag, " at_min"}, 32'(mn0), 32'(m0 == 0));
      chk({tag, " at_max"}, 32'(mx0), 32'(m0 == NR - 1));
      chk({tag, " pulses"}, 32'(p0), 32'(e0));
      chk({tag, " w idx"}, 32'(idx1), 32'(m1));
      chk({tag, " w n"}, 32'(n1), 32'(n_tbl[m1]));
      chk({tag, " w fc"}, 32'(fc1), 32'(fc_tbl[m1]));
      chk({tag, " w pulses"}, 32'(p1), 32'(e1));
   endtask
   task automatic model_step(input bit up);
      int n0_, n1_;
      n0_ = up ? (m0 == NR - 1 ? m0 : m0 + 1) : (m0 == 0 ? 0 : m0 - 1);
      n1_ = up ? (m1 + 1) % NR : (m1 + NR - 1) % NR;
      e0 += int'(n0_ != m0);
      e1 += int'(n1_ != m1);
      m0 = n0_;
      m1 = n1_;
   endtask
   task automatic model_home();
      e0 += int'(m0 != INIT);
      e1 += int'(m1 != INIT);
      m0 = INIT;
      m1 = INIT;
   endtask
   task automatic do_up();
      b = 1'b0; hold(10);
      a = 1'b0; hold(10);
      a = 1'b1; hold(10);
      b = 1'b1; hold(10);
      model_step(1'b1);
      settle_check("up");
   endtask
   task automatic do_down();
      a = 1'b0; hold(10);
      a = 1'b1; hold(10);
      model_step(1'b0);
      settle_check("down");
   endtask
   task automatic do_key();
      key_n = 1'b0; hold(10);
      key_n = 1'b1; hold(10);
      model_home();
      settle_check("key");
   endtask
   task automatic do_glitch(input bit on_key, input int k);
      if (on_key) key_n = 1'b0; else a = 1'b0;
      hold(k);
      key_n = 1'b1;
      a = 1'b1;
      hold(12);
      settle_check("glitch");
   endtask
   initial begin
      rst = 1'b1; a = 1'b1; b = 1'b1; key_n = 1'b1;
      hold(3);
      chk("rst idx", 32'(idx0), 0);
      chk("rst n", 32'(n0), 1);
      chk("rst fc", 32'(fc0), 2000000);
      chk("rst changed", 32'(ch0), 0);
      chk("rst at_min", 32'(mn0), 1);
      chk("rst at_max", 32'(mx0), 0);
      rst = 1'b0;
      hold(10);
      settle_check("idle");
      b = 1'b0; hold(10);
      a = 1'b0; hold(10);
      a = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("lat idx E0+5", 32'(idx0), 0);
      @(posedge clk);
      #1 chk("lat idx E0+6", 32'(idx0), 1);
      chk("lat n E0+6", 32'(n0), 1);
      chk("lat changed E0+6", 32'(ch0), 0);
      @(posedge clk);
      #1 chk("lat n E0+7", 32'(n0), 2);
      chk("lat fc E0+7", 32'(fc0), 1000000);
      chk("lat changed E0+7", 32'(ch0), 1);
      @(posedge clk);
      #1 chk("lat changed E0+8", 32'(ch0), 0);
      hold(10);
      b = 1'b1; hold(10);
      model_step(1'b1);
      settle_check("single up");
      do_key();
      base0 = p0; base1 = p1;
      for (int i = 0; i < 8; i++) do_up();
      chk("sat idx", 32'(idx0), 6);
      chk("sat at_max", 32'(mx0), 1);
      chk("sat pulses", 32'(p0 - base0), 6);
      chk("wrap idx", 32'(idx1), 1);
      chk("wrap pulses", 32'(p1 - base1), 8);
      do_key();
      for (int i = 0; i < 3; i++) do_up();
      base0 = p0;
      do_down();
      chk("down n", 32'(n0), 4);
      do_key();
      chk("home fc", 32'(fc0), 2000000);
      chk("down/key pulses", 32'(p0 - base0), 2);
      do_glitch(1'b0, 3);
      do_glitch(1'b1, 2);
      do_up();
      do_up();
      b = 1'b0; hold(10);
      a = 1'b0; hold(10);
      a = 1'b1; key_n = 1'b0; hold(12);
      key_n = 1'b1; hold(10);
      b = 1'b1; hold(10);
      model_home();
      settle_check("key+up");
      do_up();
      do_up();
      b = 1'b0; hold(10);
      a = 1'b0; hold(10);
      a = 1'b1; hold(2);
      rst = 1'b1; hold(2);
      chk("midrst idx", 32'(idx0), 0);
      chk("midrst n", 32'(n0), 1);
      chk("midrst changed", 32'(ch0), 0);
      rst = 1'b0;
      m0 = INIT; m1 = INIT;
      hold(20);
      b = 1'b1; hold(10);
      settle_check("post rst");
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0, 1: do_up();
            2: do_down();
            3: do_key();
            default: do_glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
         endcase
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
